alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Multi-cycle execute controller that sits directly upstream of the 4-bit ALU in the 5-bit CPU.
- Accepts 5-bit instructions over a valid/ready handshake and holds a 4-entry x DATA_W register file.
- Drives the ALU operands and op code, then captures the ALU result and flags into the register file and a flag register.
- Supports load-direct (LD) of an external data word.

Parameters:
- DATA_W, 4, width of registers, ALU operands and result.
- RA_W, 2, register address width; the register file has 2**RA_W entries (R0..R3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction present on instr.
- instr  in  5  [4:2] opcode, [1:0] rd.
- instr_ready  out  1  controller can accept an instruction this cycle.
- ld_data  in  DATA_W  direct-load operand, sampled at LD accept.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_op  out  2  ALU op code.
- alu_r  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_cf, alu_sf, alu_zf  in  1 each  ALU carry, sign and zero flags.
- cf, sf, zf  out  1 each  registered flag outputs.
- wb_valid  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  high after HLT is executed.
- dbg_sel  in  RA_W  register select for debug read.
- dbg_data  out  DATA_W  combinational read of reg[dbg_sel].

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all registers, cf/sf/zf, alu_a, alu_b, alu_op, wb_valid and halted = 0; instr_ready=1 once reset deasserts.
- Reset mid-instruction discards the in-flight instruction; no register or flag write occurs.
- Opcodes and ALU op encoding:
  - 000 ADD, alu_op=00: rd <= R0 + rd.
  - 001 SUB, alu_op=01: rd <= R0 - rd.
  - 010 AND, alu_op=10.
  - 011 OR, alu_op=11.
  - 100 LD: rd <= ld_data; flags unchanged.
  - 101 CMP: alu_op=01; flags updated, no register write.
  - 110 NOP.
  - 111 HLT.
- Operand mapping: alu_a = R0, alu_b = reg[rd]. With rd=0 the ALU sees R0 op R0.
- State IDLE:
  - instr_ready=1.
  - On instr_valid: latch instr (and ld_data for LD), go to EXEC.
  - instr_valid low: stay in IDLE.
- State EXEC:
  - instr_ready=0.
  - alu_a/alu_b/alu_op are registered outputs driven valid for the whole state; go to WB.
- State WB:
  - instr_ready=0; sample alu_r and flags.
  - ALU ops write rd and update cf/sf/zf. CMP updates flags only. LD writes rd with the latched ld_data. NOP writes nothing.
  - wb_valid=1 for this cycle; go to IDLE.
  - HLT goes to HALT instead of IDLE and sets halted=1 (wb_valid still pulses).
- State HALT: instr_ready=0; stays until reset.
- Latency: accept to wb_valid = 2 cycles. Throughput: 1 instruction per 3 cycles.
- Arithmetic: results truncated to DATA_W. Flags are taken verbatim from the ALU; this block does not recompute them.
- instr_valid while instr_ready=0 is ignored. The source must hold the instruction until it sees ready; there is no buffering.
- Simultaneous register write and dbg read of the same register: dbg_data shows the old value until the write edge.

Optional Feature:
- Macro: ALU_EXEC_FAST_EN.
- Defined:
  - WB merges into EXEC. alu_a/alu_b/alu_op are driven combinationally from the latched instruction in EXEC.
  - Writeback and wb_valid occur in EXEC; accept to wb_valid = 1 cycle; throughput 1 instruction per 2 cycles.
  - instr_ready=0 in EXEC.
- Undefined: the 3-state sequence above.

Test Plan:
- Reset then LD R0=3, LD R1=3, ADD rd=1 -> R1=6 (0110); cf=0, zf=0, sf=0; wb_valid pulses 2 cycles after each accept.
- R0=4, R1=4, CMP rd=1 -> zf=1, R1 still 4; then SUB rd=1 -> R1=0, zf=1.
- R0=12, R1=5, ADD rd=1 -> R1=1 (truncated), cf=1; a following LD R2=9 leaves cf=1.
- Hold instr_valid=1 continuously with 4 instructions -> exactly 4 accepts, each 3 cycles apart; instructions presented while ready=0 are not executed twice.
- Assert reset during EXEC of ADD rd=1 with R1=2 -> after reset all registers 0, flags 0, no wb_valid, instr_ready=1.
- HLT -> halted=1 and instr_ready=0; further instr_valid ignored for 10 cycles. With ALU_EXEC_FAST_EN, repeat the first scenario -> wb_valid 1 cycle after accept.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : alu_exec_ctrl                                                   |
// | Multi-cycle execute controller driving a 4-bit ALU; holds a small        |
// | register file and flag register. ALU_EXEC_FAST_EN merges WB into EXEC.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_exec_ctrl #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [4:0]        instr,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_cf,
    input  logic              alu_sf,
    input  logic              alu_zf,
    output logic              cf,
    output logic              sf,
    output logic              zf,
    output logic              wb_valid,
    output logic              halted,
    input  logic [RA_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int         c_NREGS  = 2**RA_W;
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_LD  = 3'b100;
    localparam logic [2:0] c_OP_CMP = 3'b101;
    localparam logic [2:0] c_OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_retire;
    logic [2:0]          r_op;
    logic [RA_W-1:0]     r_rd;
    logic [DATA_W-1:0]   r_ld_data;
    logic [DATA_W-1:0]   r_regs [c_NREGS];

    // CMP shares the subtract encoding; non-ALU ops park the ALU on ADD.
    function automatic logic [1:0] alu_code(input logic [2:0] op);
        case (op)
            c_OP_ADD: alu_code = 2'b00;
            c_OP_SUB: alu_code = 2'b01;
            c_OP_AND: alu_code = 2'b10;
            c_OP_OR:  alu_code = 2'b11;
            c_OP_CMP: alu_code = 2'b01;
            default:  alu_code = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        w_accept    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef ALU_EXEC_FAST_EN
                w_retire = 1'b1;
                w_next   = (r_op == c_OP_HLT) ? S_HALT : S_IDLE;
`else
                w_next   = S_WB;
`endif
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = (r_op == c_OP_HLT) ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        wb_valid = w_retire;
        halted   = (r_state == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= '0;
            r_rd      <= '0;
            r_ld_data <= '0;
        end else if (w_accept) begin
            r_op      <= instr[4:2];
            r_rd      <= instr[RA_W-1:0];
            r_ld_data <= ld_data;
        end
    end

`ifdef ALU_EXEC_FAST_EN
    assign alu_a  = r_regs[0];
    assign alu_b  = r_regs[r_rd];
    assign alu_op = alu_code(r_op);
`else
    // Operands are captured at accept so they are stable across EXEC and WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (w_accept) begin
            alu_a  <= r_regs[0];
            alu_b  <= r_regs[instr[RA_W-1:0]];
            alu_op <= alu_code(instr[4:2]);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
            cf <= 1'b0;
            sf <= 1'b0;
            zf <= 1'b0;
        end else if (w_retire) begin
            case (r_op)
                c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                    r_regs[r_rd] <= alu_r;
                    cf           <= alu_cf;
                    sf           <= alu_sf;
                    zf           <= alu_zf;
                end
                c_OP_CMP: begin
                    cf <= alu_cf;
                    sf <= alu_sf;
                    zf <= alu_zf;
                end
                c_OP_LD: begin
                    r_regs[r_rd] <= r_ld_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_data = r_regs[dbg_sel];

endmodule
`default_nettype wire
